// File: rtl/fifo.sv
// fifo: first-word-fall-through FIFO with register-file storage and registered full/empty flags
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, w_ptr_succ;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d, r_ptr_succ;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  wr_ok, rd_ok;
    // a pop while full frees the slot the concurrent push lands in; a read from empty is never accepted
    always_comb begin
        wr_ok      = wr & (~full_q | rd);
        rd_ok      = rd & ~empty_q;
        w_ptr_succ = w_ptr_q + 1'b1;
        r_ptr_succ = r_ptr_q + 1'b1;
        w_ptr_d    = wr_ok ? w_ptr_succ : w_ptr_q;
        r_ptr_d    = rd_ok ? r_ptr_succ : r_ptr_q;
        full_d     = (wr_ok & ~rd_ok) ? (w_ptr_succ == r_ptr_q) : (rd_ok & ~wr_ok) ? 1'b0 : full_q;
        empty_d    = (wr_ok & ~rd_ok) ? 1'b0 : (rd_ok & ~wr_ok) ? (r_ptr_succ == w_ptr_q) : empty_q;
    end
    // pointers and flags; reset discards contents by collapsing both pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end
    // storage is never cleared; reset only blocks the write in its cycle
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) mem_q[w_ptr_q] <= w_data;
    end
    assign r_data = mem_q[r_ptr_q];
    assign empty  = empty_q;
    assign full   = full_q;
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed scoreboard bench for the fifo at depth 4
module tb_fifo;
    logic       clk = 1'b0;
    logic       reset, rd, wr;
    logic [7:0] w_data, r_data;
    logic       empty, full;
    logic [7:0] sb[$];
    int         vectors = 0;
    int         errs = 0;

    fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr),
        .w_data(w_data), .r_data(r_data), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".empty"}, {7'd0, empty}, {7'd0, sb.size() == 0});
        check({tag, ".full"}, {7'd0, full}, {7'd0, sb.size() == 4});
        if (sb.size() != 0) check({tag, ".head"}, r_data, sb[0]);
    endtask

    task automatic step(input string tag, input logic r, input logic w, input logic [7:0] d);
        logic ra, wa;
        logic [7:0] exp;
        rd = r;
        wr = w;
        w_data = d;
        ra = r && sb.size() > 0;
        wa = w && (sb.size() < 4 || r);
        if (ra) begin
            exp = sb.pop_front();
            #1 check({tag, ".pop"}, r_data, exp);
        end
        if (wa) sb.push_back(d);
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        rd = 1'b1;
        wr = 1'b1;
        w_data = 8'd55;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        sb.delete();
        check_state(tag);
    endtask

    initial begin
        reset = 1'b1;
        rd = 1'b0;
        wr = 1'b0;
        w_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_state("reset");
        step("rd_empty0", 1'b1, 1'b0, 8'd0);
        step("rd_empty1", 1'b1, 1'b0, 8'd0);
        step("push1", 1'b0, 1'b1, 8'd1);
        step("push_m2", 1'b0, 1'b1, -8'sd2);
        step("push3", 1'b0, 1'b1, 8'd3);
        step("push_m4", 1'b0, 1'b1, -8'sd4);
        step("slide5", 1'b1, 1'b1, 8'd5);
        step("slide_m6", 1'b1, 1'b1, -8'sd6);
        step("slide7", 1'b1, 1'b1, 8'd7);
        step("slide_m8", 1'b1, 1'b1, -8'sd8);
        step("slide9", 1'b1, 1'b1, 8'd9);
        step("wr_full", 1'b0, 1'b1, 8'd99);
        for (int i = 0; i < 4; i++) step("drain", 1'b1, 1'b0, 8'd0);
        step("rdwr_empty", 1'b1, 1'b1, 8'd7);
        step("push2nd", 1'b0, 1'b1, 8'd20);
        do_reset("mid_reset");
        step("push11", 1'b0, 1'b1, 8'd11);
        step("push12", 1'b0, 1'b1, 8'd12);
        step("pop11", 1'b1, 1'b0, 8'd0);
        step("pop12", 1'b1, 1'b0, 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
